lfsr_gen: RTL and testbench
===========================

LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 SHALL have parameter NUM_BITS, default 8: state width, legal range 3..32.
REQ-002 SHALL have parameter STEPS, default 1: LFSR shifts per advance, legal range 1..8.
REQ-003 SHALL have parameter DEFAULT_SEED, default 1 (NUM_BITS wide, non-zero): reset and recovery state.
REQ-004 SHALL have port i_Clk  input  1  rising-edge clock; the block has one clock.
REQ-005 SHALL have port i_Rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_Enable  input  1  permits advancing.
REQ-007 SHALL have port i_Seed_DV  input  1  one-cycle strobe to load i_Seed_Data.
REQ-008 SHALL have port i_Seed_Data  input  NUM_BITS  seed value.
REQ-009 SHALL have port i_Taps_DV  input  1  one-cycle strobe to load i_Taps.
REQ-010 SHALL have port i_Taps  input  NUM_BITS  feedback tap mask (bit k set = state bit k taps).
REQ-011 SHALL have port i_Ready  input  1  consumer accepts o_LFSR_Data.
REQ-012 SHALL have port o_Valid  output  1  o_LFSR_Data holds an unconsumed value.
REQ-013 SHALL have port o_LFSR_Data  output  NUM_BITS  current state, registered.
REQ-014 SHALL have port o_LFSR_Done  output  1  one-cycle pulse when the sequence returns to the reference state.
REQ-015 SHALL have port o_Lockup  output  1  state is all-zero.
REQ-016 SHALL have port o_Count  output  NUM_BITS  advances since last reference point.

Function
REQ-017 SHALL implement a Fibonacci XOR LFSR per step: fb = XOR of (state AND taps); state <= {state[NUM_BITS-2:0], fb}.
REQ-018 SHALL reset the tap register to a built-in maximal-length mask for NUM_BITS (for NUM_BITS=4: 4'b1100, x^4+x^3+1).
REQ-019 SHALL define adv = i_Enable & (i_Ready | ~o_Valid) & ~i_Seed_DV & ~i_Taps_DV.
REQ-020 SHALL, on adv, apply STEPS successive steps in one cycle and set o_Valid = 1.
REQ-021 SHALL, when o_Valid & i_Ready & ~adv, clear o_Valid to 0 next cycle.
REQ-022 SHALL hold o_LFSR_Data and o_Valid unchanged while o_Valid = 1 and i_Ready = 0.
REQ-023 SHALL, on i_Seed_DV (highest priority), load state and reference register with i_Seed_Data, clear o_Valid and o_Count, with no advance that cycle.
REQ-024 SHALL, on i_Taps_DV, load taps, copy current state to the reference register, clear o_Count, and leave state and o_Valid unchanged; if simultaneous with i_Seed_DV, both loads occur and the reference becomes i_Seed_Data.
REQ-025 SHALL pulse o_LFSR_Done for exactly one cycle after an adv in which any of the STEPS intermediate states equals the reference register.
REQ-026 SHALL increment o_Count by 1 per adv, wrap from all-ones to 0, and clear it to 0 on a Done-producing adv.
REQ-027 SHALL drive o_Lockup = 1 whenever the state register is all-zero.
REQ-028 SHALL, on adv while state is all-zero, load DEFAULT_SEED (no stepping) and set the reference register to DEFAULT_SEED.

Reset
REQ-029 SHALL, on i_Rst asserted, immediately and without a clock edge set state = DEFAULT_SEED, reference = DEFAULT_SEED, taps = default mask, o_Valid = 0, o_LFSR_Done = 0, o_Lockup = 0, o_Count = 0.
REQ-030 SHALL resume normal operation on the first rising i_Clk edge after i_Rst deasserts, including when reset was asserted mid-sequence.

Verification (NUM_BITS=4, DEFAULT_SEED=0001, default taps unless stated)
REQ-031 SHALL cover free run: reset, i_Enable=1, i_Ready=1 -> data 0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,1111,1110,1100,1000,0001; Done pulses once with 0001; o_Count reads 14 before the wrap and 0 after.
REQ-032 SHALL cover STEPS=4: the first adv from 0001 gives 0011; Done pulses on the 4th adv, when step 15 returns to 0001.
REQ-033 SHALL cover backpressure: o_Valid=1, i_Ready=0 for 5 cycles -> o_LFSR_Data and o_Count constant, no Done.
REQ-034 SHALL cover mid-run seed load of 1010 -> next cycle data 1010, o_Valid 0, o_Count 0; following advs give 0101, 1011; Done when 1010 recurs 15 advs later.
REQ-035 SHALL cover a zero seed: load 0000 -> o_Lockup 1; next adv -> data 0001, o_Lockup 0.
REQ-036 SHALL cover async reset mid-run: i_Rst asserted between clock edges -> outputs take reset values before the next edge.

Source files
------------

// File: rtl/lfsr_gen.sv
// lfsr_gen: Fibonacci XOR LFSR with STEPS shifts per advance, valid/ready
// output handshake, runtime seed and tap loading, period detection and
// all-zero lockup recovery.
//
// Ports:
//   i_Clk        rising-edge clock
//   i_Rst        asynchronous active-high reset
//   i_Enable     permits advancing
//   i_Seed_DV    strobe: load i_Seed_Data into state and reference
//   i_Seed_Data  seed value
//   i_Taps_DV    strobe: load i_Taps, re-reference at the current state
//   i_Taps       feedback tap mask (bit k set = state bit k taps)
//   i_Ready      consumer accepts o_LFSR_Data
//   o_Valid      o_LFSR_Data holds an unconsumed value
//   o_LFSR_Data  current state
//   o_LFSR_Done  one-cycle pulse when the sequence revisits the reference
//   o_Lockup     state is all-zero
//   o_Count      advances since the last reference point
module lfsr_gen #(
  parameter int                  NUM_BITS     = 8,
  parameter int                  STEPS        = 1,
  parameter logic [NUM_BITS-1:0] DEFAULT_SEED = {{(NUM_BITS-1){1'b0}}, 1'b1}
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Enable,
  input  logic                i_Seed_DV,
  input  logic [NUM_BITS-1:0] i_Seed_Data,
  input  logic                i_Taps_DV,
  input  logic [NUM_BITS-1:0] i_Taps,
  input  logic                i_Ready,
  output logic                o_Valid,
  output logic [NUM_BITS-1:0] o_LFSR_Data,
  output logic                o_LFSR_Done,
  output logic                o_Lockup,
  output logic [NUM_BITS-1:0] o_Count
);

  // Maximal-length tap masks; bit (n-1) set means stage n feeds back.
  function automatic logic [31:0] max_taps(input int n);
    case (n)
      3:  return 32'h0000_0006;
      4:  return 32'h0000_000C;
      5:  return 32'h0000_0014;
      6:  return 32'h0000_0030;
      7:  return 32'h0000_0060;
      8:  return 32'h0000_00B8;
      9:  return 32'h0000_0110;
      10: return 32'h0000_0240;
      11: return 32'h0000_0500;
      12: return 32'h0000_0829;
      13: return 32'h0000_100D;
      14: return 32'h0000_2015;
      15: return 32'h0000_6000;
      16: return 32'h0000_D008;
      17: return 32'h0001_2000;
      18: return 32'h0002_0400;
      19: return 32'h0004_0023;
      20: return 32'h0009_0000;
      21: return 32'h0014_0000;
      22: return 32'h0030_0000;
      23: return 32'h0042_0000;
      24: return 32'h00E1_0000;
      25: return 32'h0120_0000;
      26: return 32'h0200_0023;
      27: return 32'h0400_0013;
      28: return 32'h0900_0000;
      29: return 32'h1400_0000;
      30: return 32'h2000_0029;
      31: return 32'h4800_0000;
      32: return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

  localparam logic [31:0]         TAPS_FULL = max_taps(NUM_BITS);
  localparam logic [NUM_BITS-1:0] DEF_TAPS  = TAPS_FULL[NUM_BITS-1:0];

  logic [NUM_BITS-1:0] state_q, ref_q, taps_q, count_q;
  logic                valid_q, done_q;
  logic                adv;
  logic [STEPS-1:0]    hit_vec;
  logic [NUM_BITS-1:0] step_out;

  assign adv = i_Enable & (i_Ready | ~valid_q) & ~i_Seed_DV & ~i_Taps_DV;

  // Unrolled step chain; every intermediate state is compared against the
  // reference so a period boundary inside a multi-step advance is caught.
  for (genvar g = 0; g < STEPS; g++) begin : g_step
    logic [NUM_BITS-1:0] cur, nxt;
    if (g == 0) begin : g_first
      assign cur = state_q;
    end else begin : g_rest
      assign cur = g_step[g-1].nxt;
    end
    assign nxt        = {cur[NUM_BITS-2:0], ^(cur & taps_q)};
    assign hit_vec[g] = (nxt == ref_q);
  end
  assign step_out = g_step[STEPS-1].nxt;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= DEFAULT_SEED;
      ref_q   <= DEFAULT_SEED;
      taps_q  <= DEF_TAPS;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (i_Seed_DV) begin
        // Seed wins the reference even when taps load in the same cycle.
        state_q <= i_Seed_Data;
        ref_q   <= i_Seed_Data;
        valid_q <= 1'b0;
        count_q <= '0;
        if (i_Taps_DV) taps_q <= i_Taps;
      end else if (i_Taps_DV) begin
        taps_q  <= i_Taps;
        ref_q   <= state_q;
        count_q <= '0;
      end else if (adv) begin
        valid_q <= 1'b1;
        if (state_q == '0) begin
          // Zero is a fixed point of an XOR LFSR: restart from the default.
          state_q <= DEFAULT_SEED;
          ref_q   <= DEFAULT_SEED;
          count_q <= count_q + NUM_BITS'(1);
        end else begin
          state_q <= step_out;
          if (|hit_vec) begin
            done_q  <= 1'b1;
            count_q <= '0;
          end else begin
            count_q <= count_q + NUM_BITS'(1);
          end
        end
      end else if (valid_q && i_Ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign o_Valid     = valid_q;
  assign o_LFSR_Data = state_q;
  assign o_LFSR_Done = done_q;
  assign o_Lockup    = (state_q == '0);
  assign o_Count     = count_q;

endmodule

// File: tb/tb_lfsr_gen.sv
module tb_lfsr_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, seed_dv = 1'b0, taps_dv = 1'b0, rdy = 1'b0;
  logic [3:0] seed_data = '0, taps = '0;

  logic       valid1, done1, lock1, valid4, done4, lock4;
  logic [3:0] data1, count1, data4, count4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lfsr_gen #(.NUM_BITS(4), .STEPS(1), .DEFAULT_SEED(4'b0001)) dut1 (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Seed_DV(seed_dv),
    .i_Seed_Data(seed_data), .i_Taps_DV(taps_dv), .i_Taps(taps),
    .i_Ready(rdy), .o_Valid(valid1), .o_LFSR_Data(data1),
    .o_LFSR_Done(done1), .o_Lockup(lock1), .o_Count(count1));

  lfsr_gen #(.NUM_BITS(4), .STEPS(4), .DEFAULT_SEED(4'b0001)) dut4 (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Seed_DV(seed_dv),
    .i_Seed_Data(seed_data), .i_Taps_DV(taps_dv), .i_Taps(taps),
    .i_Ready(rdy), .o_Valid(valid4), .o_LFSR_Data(data4),
    .o_LFSR_Done(done4), .o_Lockup(lock4), .o_Count(count4));

  // Reference model: index 0 mirrors STEPS=1, index 1 mirrors STEPS=4.
  int steps_of [2] = '{1, 4};
  int ms [2], mr [2], mt [2], mv [2], md [2], mc [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ms[i] = 1; mr[i] = 1; mt[i] = 12; mv[i] = 0; md[i] = 0; mc[i] = 0;
    end
  endtask

  // One clock edge worth of behaviour, from the current inputs.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit a, hit;
      a = en && (rdy || mv[i] == 0) && !seed_dv && !taps_dv;
      md[i] = 0;
      if (seed_dv) begin
        ms[i] = int'(seed_data); mr[i] = int'(seed_data); mv[i] = 0; mc[i] = 0;
        if (taps_dv) mt[i] = int'(taps);
      end else if (taps_dv) begin
        mt[i] = int'(taps); mr[i] = ms[i]; mc[i] = 0;
      end else if (a) begin
        mv[i] = 1;
        if (ms[i] == 0) begin
          ms[i] = 1; mr[i] = 1; mc[i] = (mc[i] + 1) % 16;
        end else begin
          hit = 0;
          for (int k = 0; k < steps_of[i]; k++) begin
            ms[i] = ((ms[i] * 2) % 16) + ($countones(ms[i] & mt[i]) % 2);
            if (ms[i] == mr[i]) hit = 1;
          end
          md[i] = hit ? 1 : 0;
          mc[i] = hit ? 0 : (mc[i] + 1) % 16;
        end
      end else if (mv[i] != 0 && rdy) begin
        mv[i] = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("valid1", 32'(valid1), 32'(mv[0]));
    check("data1",  32'(data1),  32'(ms[0]));
    check("done1",  32'(done1),  32'(md[0]));
    check("lock1",  32'(lock1),  32'(ms[0] == 0));
    check("count1", 32'(count1), 32'(mc[0]));
    check("valid4", 32'(valid4), 32'(mv[1]));
    check("data4",  32'(data4),  32'(ms[1]));
    check("done4",  32'(done4),  32'(md[1]));
    check("lock4",  32'(lock4),  32'(ms[1] == 0));
    check("count4", 32'(count4), 32'(mc[1]));
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int seq [15] = '{2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8, 1};

    // Reset state
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Free run
    en = 1'b1; rdy = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      cycle();
      check("fr_data", 32'(data1), 32'(seq[i-1]));
      if (i == 1)  check("s4_first", 32'(data4), 32'h3);
      if (i == 4)  check("s4_done", 32'(done4), 32'h1);
      if (i == 14) check("fr_cnt14", 32'(count1), 32'd14);
      if (i == 15) begin
        check("fr_done", 32'(done1), 32'h1);
        check("fr_wrap", 32'(count1), 32'h0);
      end
    end

    // Backpressure
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_data", 32'(data1), 32'h1);
      check("bp_cnt", 32'(count1), 32'h0);
      check("bp_done", 32'(done1), 32'h0);
    end
    rdy = 1'b1;

    // Mid-run seed load
    seed_data = 4'hA; seed_dv = 1'b1;
    cycle();
    seed_dv = 1'b0;
    check("sd_data", 32'(data1), 32'hA);
    check("sd_valid", 32'(valid1), 32'h0);
    check("sd_cnt", 32'(count1), 32'h0);
    cycle(); check("sd_n1", 32'(data1), 32'h5);
    cycle(); check("sd_n2", 32'(data1), 32'hB);
    for (int i = 3; i <= 15; i++) cycle();
    check("sd_done", 32'(done1), 32'h1);
    check("sd_back", 32'(data1), 32'hA);

    // Zero seed lockup and recovery
    seed_data = 4'h0; seed_dv = 1'b1;
    cycle();
    seed_dv = 1'b0;
    check("lk_on", 32'(lock1), 32'h1);
    cycle();
    check("lk_data", 32'(data1), 32'h1);
    check("lk_off", 32'(lock1), 32'h0);

    // Async reset between edges
    for (int i = 0; i < 3; i++) cycle();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    check("ar_data", 32'(data1), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    cycle();
    check("ar_resume", 32'(data1), 32'h2);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom_range(0, 3) != 0);
      rdy       = ($urandom_range(0, 1) != 0);
      seed_dv   = ($urandom_range(0, 39) == 0);
      seed_data = 4'($urandom);
      taps_dv   = ($urandom_range(0, 49) == 0);
      taps      = ($urandom_range(0, 1) != 0) ? 4'h9 : 4'hC;
      cycle();
    end
    seed_dv = 1'b0; taps_dv = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
